// File: rtl/norm_shift_pkg.sv
// Shared definitions for the normalizing left shifter: state encoding,
// datapath widths and a leading-nibble helper.
package norm_shift_pkg;

  localparam int NS_WIDTH = 16;
  localparam int NS_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // True when the top four bits of the operand are all zero.
  function automatic logic nibble_clear(input logic [NS_WIDTH-1:0] v);
    return (v[NS_WIDTH-1:NS_WIDTH-4] == 4'h0);
  endfunction

endpackage

// File: rtl/left_shift_reg.sv
// 16-bit datapath register for the normalizing shifter: load, shift left by
// one, and (when NORM_LSHIFT_NIBBLE_SKIP_EN is defined) shift left by four.
// Vacated LSBs are always filled with zeros.
module left_shift_reg
  import norm_shift_pkg::*;
#(
  parameter int WIDTH = NS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             shift_enable,
`ifdef NORM_LSHIFT_NIBBLE_SKIP_EN
  input  logic             shift4,
`endif
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next register value: load has priority over any shift, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = in_data;
    end
`ifdef NORM_LSHIFT_NIBBLE_SKIP_EN
    else if (shift4) begin
      q_d = {q_q[WIDTH-5:0], 4'b0000};
    end
`endif
    else if (shift_enable) begin
      q_d = {q_q[WIDTH-2:0], 1'b0};
    end else begin
      q_d = q_q;
    end
  end

  // Datapath register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/norm_left_shifter.sv
// Sequential normalizing left shifter. Loads an operand on an accepted start,
// shifts left until bit 15 is set (or the operand is found to be zero) and
// reports the number of positions shifted through a start/busy/done handshake.
// Optional build macro NORM_LSHIFT_NIBBLE_SKIP_EN: shift by four whenever the
// top nibble is clear, reducing the cycle count without changing results.
module norm_left_shifter
  import norm_shift_pkg::*;
#(
  parameter int WIDTH = NS_WIDTH,
  parameter int CNT_W = NS_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] shift_count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ld_s;
  logic             sh1_s;
  logic             sh4_s;
  logic [WIDTH-1:0] reg_s;

  left_shift_reg #(.WIDTH(WIDTH)) u_reg (
    .clk          (clk),
    .rst          (rst),
    .ld           (ld_s),
    .shift_enable (sh1_s),
`ifdef NORM_LSHIFT_NIBBLE_SKIP_EN
    .shift4       (sh4_s),
`endif
    .in_data      (in),
    .q            (reg_s)
  );

  // Controller: next state, counter, flags and datapath controls.
  // done_d is raised on the transition into DONE so the registered pulse
  // coincides with the DONE state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    ld_s    = 1'b0;
    sh1_s   = 1'b0;
    sh4_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ld_s    = 1'b1;
          cnt_d   = {CNT_W{1'b0}};
          zero_d  = 1'b0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (reg_s == {WIDTH{1'b0}}) begin
          zero_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (reg_s[WIDTH-1]) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
`ifdef NORM_LSHIFT_NIBBLE_SKIP_EN
        else if (nibble_clear(reg_s)) begin
          sh4_s = 1'b1;
          cnt_d = cnt_q + 4'd4;
        end
`endif
        else begin
          sh1_s = 1'b1;
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM state and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign out         = reg_s;
  assign shift_count = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign zero        = zero_q;

  // sh4_s only drives the datapath in the nibble-skip build.
  logic unused_s;
  assign unused_s = sh4_s;

endmodule

// File: tb/tb_norm_left_shifter.sv
// Scoreboard bench for norm_left_shifter: the stimulus process pushes the
// expected result of each accepted operand, a monitor pops and compares on
// every done pulse. Expected values come from a leading-zero reference model.
module tb_norm_left_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in_v;
  logic [15:0] out_v;
  logic [3:0]  cnt_v;
  logic        busy_v;
  logic        done_v;
  logic        zero_v;

  always #5 clk = ~clk;

  norm_left_shifter dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in          (in_v),
    .out         (out_v),
    .shift_count (cnt_v),
    .busy        (busy_v),
    .done        (done_v),
    .zero        (zero_v)
  );

  typedef struct {
    logic [15:0] op;
    logic [15:0] e_out;
    int          e_cnt;
    logic        e_zero;
    int          e_cycle;  // cycle index of done, cycle 0 = start edge
    int          t0;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lzc(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) return 15 - i;
    end
    return 16;
  endfunction

  // Reference: normalize with plain arithmetic; cycle count from lz.
  function automatic exp_t model(input logic [15:0] v);
    exp_t e;
    int   lz;
    int   s;
    lz = lzc(v);
    e.op = v;
    e.t0 = 0;
    if (lz == 16) begin
      e.e_out = 16'h0000;
      e.e_cnt = 0;
      e.e_zero = 1'b1;
      s = 0;
    end else begin
      e.e_out = 16'(v << lz);
      e.e_cnt = lz;
      e.e_zero = 1'b0;
`ifdef NORM_LSHIFT_NIBBLE_SKIP_EN
      s = lz / 4 + lz % 4;
`else
      s = lz;
`endif
    end
    e.e_cycle = s + 2;
    return e;
  endfunction

  // Monitor: compare every done pulse with the oldest expectation.
  bit prev_done = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (prev_done) chk("busy_fall", busy_v, 1'b0);
      prev_done = done_v;
      if (done_v) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", done_v, 1'b0);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("out[%h]", e.op), out_v, e.e_out);
          chk($sformatf("cnt[%h]", e.op), cnt_v, e.e_cnt);
          chk($sformatf("zero[%h]", e.op), zero_v, e.e_zero);
          chk($sformatf("busy_done[%h]", e.op), busy_v, 1'b1);
          chk($sformatf("done_cycle[%h]", e.op), cyc - e.t0 + 1, e.e_cycle);
        end
      end
    end
  end

  task automatic issue(input logic [15:0] v, output exp_t e);
    @(negedge clk);
    in_v  = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    e = model(v);
    e.t0 = cyc;
    sbq.push_back(e);
    start = 1'b0;
    in_v  = 16'($urandom);
    chk("busy_rise", busy_v, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain_timeout", sbq.size(), 0);
    sbq.delete();
    @(posedge clk);
    #2;
  endtask

  task automatic run_op(input logic [15:0] v);
    exp_t e;
    issue(v, e);
    drain();
    repeat (2) @(negedge clk);
    chk("hold_out", out_v, e.e_out);
    chk("hold_cnt", cnt_v, e.e_cnt);
    chk("hold_zero", zero_v, e.e_zero);
    chk("idle_busy", busy_v, 1'b0);
  endtask

  initial begin
    exp_t e;
    int   lz;
    logic [15:0] v;
    rst   = 1'b1;
    start = 1'b0;
    in_v  = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out_v, 16'h0000);
    chk("rst_cnt", cnt_v, 4'h0);
    chk("rst_busy", busy_v, 1'b0);
    chk("rst_done", done_v, 1'b0);
    chk("rst_zero", zero_v, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h00F0);
    run_op(16'h0001);
    run_op(16'h0000);
    run_op(16'h8123);

    // A start while busy must be ignored and not queued.
    issue(16'h0010, e);
    repeat (3) @(negedge clk);
    in_v  = 16'h4000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    chk("ign_out", out_v, 16'h8000);
    chk("ign_cnt", cnt_v, 4'd11);
    repeat (3) @(negedge clk);
    chk("ign_no_second", busy_v, 1'b0);

    // Reset in the middle of a run clears everything.
    issue(16'h0001, e);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    chk("mid_rst_out", out_v, 16'h0000);
    chk("mid_rst_cnt", cnt_v, 4'h0);
    chk("mid_rst_busy", busy_v, 1'b0);
    chk("mid_rst_zero", zero_v, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0001);

    for (int n = 0; n < 24; n++) begin
      lz = $urandom_range(0, 16);
      if (lz == 16) v = 16'h0000;
      else v = (16'($urandom) | 16'h8000) >> lz;
      run_op(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/norm_left_shifter.md
# norm_left_shifter

Sequential 16-bit normalizing left shifter. It loads an operand, then shifts it left one position per clock until bit 15 is 1, and reports the number of positions shifted. It is the counterpart of the datapath's right shifter: this block normalizes an operand before the arithmetic stage, and the right shifter uses `shift_count` afterwards to restore the scale. A start/busy/done handshake connects it to the top-level controller.

## Interface
Parameters:
- `WIDTH`, 16: operand width. Only 16 is supported.
- `CNT_W`, 4: shift-count width, equal to log2(`WIDTH`).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to load `in` and begin normalization; honoured only in IDLE.
- `in`  in  16  operand, sampled on the accepted `start` edge.
- `out`  out  16  shift register contents; after `done`, the normalized operand.
- `shift_count`  out  4  number of positions shifted left.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when the result is valid.
- `zero`  out  1  high when the loaded operand was 0; holds until the next accepted `start`.

## Operation
- States:
  - IDLE: waits for `start`.
  - SHIFT: each cycle, checks the register and shifts it or ends.
  - DONE: pulses `done`.
- IDLE:
  - With `start`=1: `out`<=`in`, `shift_count`<=0, `zero`<=0, go to SHIFT.
  - With `start`=0: hold all outputs.
- SHIFT, checked in this priority order:
  - `out`==0: `zero`<=1, go to DONE.
  - `out[15]`==1: go to DONE without shifting.
  - Otherwise: `out`<={`out[14:0]`,1'b0}, `shift_count`<=`shift_count`+1, stay in SHIFT.
- DONE: `done`=1 for this cycle only, then go to IDLE.
- `out`, `shift_count` and `zero` hold their final values through IDLE until the next accepted `start`.
- Arithmetic:
  - `shift_count` cannot exceed 15, because a nonzero operand has bit 15 set after at most 15 shifts. No wrap handling is needed.
  - The LSB is always filled with 0.
- Boundary conditions:
  - `start` in SHIFT or DONE is ignored and not queued.
  - `start` in the cycle where `done`=1 is ignored. The earliest accepted `start` is in the following IDLE cycle.
  - Operand already normalized (bit 15 = 1): `shift_count`=0, `out` equals `in`.
  - `rst` at any time, including mid-shift, goes to IDLE and clears every output.

## Timing
- Reset values: `out`=0, `shift_count`=0, `busy`=0, `done`=0, `zero`=0, state=IDLE.
- Define cycle 0 as the edge that samples `start`. Then:
  - `busy` rises after cycle 0.
  - `done` is high in cycle s+2, where s is the number of shifting cycles.
  - `busy` falls in the cycle after `done`.
- Without skip, s equals the number of leading zeros of `in`. Worst case for a nonzero operand is 0x0001: s=15, `done` in cycle 17.
- Zero operand: `done` in cycle 2, with `zero`=1 and `shift_count`=0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `NORM_LSHIFT_NIBBLE_SKIP_EN`.
- Defined:
  - In SHIFT, when `out`!=0 and `out[15:12]`==0, the cycle shifts left by 4 and adds 4 to `shift_count`.
  - The zero check keeps its priority over the skip.
  - Otherwise, single-bit behaviour is unchanged.
  - s becomes floor(lz/4) + (lz mod 4), where lz is the number of leading zeros of `in`.
- Undefined: single-bit shifting only, as in Operation. No nibble-detect logic is synthesized.
- `out` and `shift_count` end with the same final values in both builds. Only the cycle count differs.

## Structure
- Shared package `norm_shift_pkg`:
  - state encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - constants `NS_WIDTH`=16 and `NS_CNT_W`=4.
- Sub-module `left_shift_reg`: the 16-bit datapath register, with controls:
  - `ld`: load `in`.
  - `shift_enable`: shift by 1.
  - `shift4`: shift by 4; present only under the macro.
  - synchronous `rst`.
- Top level contains the FSM, the counter, and the zero/MSB detection.

## Test plan
- Reset: assert `rst` for 2 cycles → all outputs 0, `busy`=0.
- `in`=0x00F0, `start` pulse:
  - Default build: `done` in cycle 10, `out`=0xF000, `shift_count`=8.
  - Skip build: `done` in cycle 4 with the same values.
- `in`=0x0001:
  - Default build: `done` in cycle 17, `out`=0x8000, `shift_count`=15.
  - Skip build: `done` in cycle 8.
- `in`=0x0000: `done` in cycle 2, `zero`=1, `out`=0, `shift_count`=0. `in`=0x8123: `done` in cycle 2, `shift_count`=0, `out`=0x8123.
- `in`=0x0010 accepted; a second `start` with 0x4000 in cycle 3 is ignored. Final `out`=0x8000, `shift_count`=11.
- `rst` asserted in cycle 5 of a 0x0001 run → outputs cleared next edge, IDLE. A fresh `start` then completes normally.
